// File: rtl/vu_pkg.sv
// Shared VU-meter definitions: level width, peak FSM states, default timing constants
// and small saturating helpers used by the level controller.
package vu_pkg;

  localparam int unsigned LEVEL_W = 8;

  localparam int unsigned DEFAULT_DECAY_STEP  = 4;
  localparam int unsigned DEFAULT_HOLD_FRAMES = 30;
  localparam int unsigned DEFAULT_PEAK_STEP   = 2;
  localparam int unsigned DEFAULT_CLIP_FRAMES = 60;
  localparam logic [LEVEL_W-1:0] DEFAULT_CLIP_THRESHOLD = 8'd240;

  typedef enum logic {
    StHold,
    StFall
  } peak_state_e;

  // a - b, clamped at zero
  function automatic logic [LEVEL_W-1:0] sat_sub(input logic [LEVEL_W-1:0] a,
                                                 input logic [LEVEL_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [LEVEL_W-1:0] max_lvl(input logic [LEVEL_W-1:0] a,
                                                 input logic [LEVEL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down counter decremented by a frame tick; stops at zero and flags it.
module frame_down_counter #(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: load wins over tick; never wraps below zero
  always_comb begin
    count_d = count_q;
    if (enable) begin
      if (load) begin
        count_d = load_value;
      end else if (tick && (count_q != '0)) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= CNT_W'(RESET_VALUE);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/vu_level_ctrl.sv
// VU-meter level sequencer: turns accepted UART sample bytes into a decaying bar level,
// a held-then-falling peak marker, a timed clip indicator and a rejected-byte count.
module vu_level_ctrl
  import vu_pkg::*;
#(
  parameter int unsigned         DECAY_STEP     = DEFAULT_DECAY_STEP,
  parameter int unsigned         HOLD_FRAMES    = DEFAULT_HOLD_FRAMES,
  parameter int unsigned         PEAK_STEP      = DEFAULT_PEAK_STEP,
  parameter logic [LEVEL_W-1:0]  CLIP_THRESHOLD = DEFAULT_CLIP_THRESHOLD,
  parameter int unsigned         CLIP_FRAMES    = DEFAULT_CLIP_FRAMES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] data_in,
  input  logic               load,
  input  logic               error,
  input  logic               frame_tick,
  output logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] peak,
  output logic               clip,
  output logic [7:0]         err_count
);

  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned CLIP_W = $clog2(CLIP_FRAMES + 1);

  if (DECAY_STEP == 0 || HOLD_FRAMES == 0 || PEAK_STEP == 0 || CLIP_FRAMES == 0 ||
      CLIP_THRESHOLD == '0) begin : g_bad_param
    $error("vu_level_ctrl: zero-valued parameter is not allowed");
  end

  logic               sample_ok;
  logic [LEVEL_W-1:0] level_q, level_d, level_dec;
  logic [LEVEL_W-1:0] peak_q, peak_d;
  peak_state_e        state_q, state_d;
  logic               clip_q, clip_d;
  logic [7:0]         err_q, err_d;

  logic               hold_load, hold_tick, hold_zero;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               clip_load, clip_tick, clip_zero;
  logic [CLIP_W-1:0]  clip_cnt;

  assign sample_ok = load & ~error;

  // Bar level: decay on the frame tick first, then let a larger sample jump it up
  always_comb begin
    level_dec = level_q;
    if (frame_tick) begin
      level_dec = sat_sub(level_q, LEVEL_W'(DECAY_STEP));
    end
    level_d = level_q;
    if (enable) begin
      level_d = sample_ok ? max_lvl(data_in, level_dec) : level_dec;
    end
  end

  // Peak FSM: a sample at or above the peak re-arms the hold; after the hold the
  // marker falls but is clamped to the new level so it never dips under the bar
  always_comb begin
    state_d   = state_q;
    peak_d    = peak_q;
    hold_load = 1'b0;
    hold_tick = 1'b0;
    if (enable) begin
      if (sample_ok && (data_in >= peak_q)) begin
        peak_d    = data_in;
        state_d   = StHold;
        hold_load = 1'b1;
      end else if (frame_tick) begin
        unique case (state_q)
          StHold: begin
            if (hold_zero) begin
              state_d = StFall;
            end else begin
              hold_tick = 1'b1;
            end
          end
          StFall: begin
            peak_d = max_lvl(sat_sub(peak_q, LEVEL_W'(PEAK_STEP)), level_d);
          end
          default: state_d = StHold;
        endcase
      end
    end
  end

  // Clip: a clipping sample reloads the timer; the flag drops on the 1 -> 0 tick
  always_comb begin
    clip_d    = clip_q;
    clip_load = 1'b0;
    clip_tick = 1'b0;
    if (enable) begin
      if (sample_ok && (data_in >= CLIP_THRESHOLD)) begin
        clip_d    = 1'b1;
        clip_load = 1'b1;
      end else if (frame_tick) begin
        clip_tick = 1'b1;
        if (clip_cnt == CLIP_W'(1)) begin
          clip_d = 1'b0;
        end
      end
    end
  end

  // Rejected-byte counter, saturating at all-ones
  always_comb begin
    err_d = err_q;
    if (enable && load && error && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      peak_q  <= '0;
      state_q <= StHold;
      clip_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      level_q <= level_d;
      peak_q  <= peak_d;
      state_q <= state_d;
      clip_q  <= clip_d;
      err_q   <= err_d;
    end
  end

  // Hold timer counts remaining hold ticks; reset value matches a freshly armed hold
  frame_down_counter #(
    .CNT_W      (HOLD_W),
    .RESET_VALUE(HOLD_FRAMES - 1)
  ) u_hold_cnt (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .load      (hold_load),
    .load_value(HOLD_W'(HOLD_FRAMES - 1)),
    .tick      (hold_tick),
    .count     (hold_cnt),
    .zero      (hold_zero)
  );

  frame_down_counter #(
    .CNT_W      (CLIP_W),
    .RESET_VALUE(0)
  ) u_clip_cnt (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .load      (clip_load),
    .load_value(CLIP_W'(CLIP_FRAMES)),
    .tick      (clip_tick),
    .count     (clip_cnt),
    .zero      (clip_zero)
  );

  // Structural invariants
  assert property (@(posedge clock) disable iff (reset) peak_q >= level_q);
  assert property (@(posedge clock) disable iff (reset) clip_q == !clip_zero);
  assert property (@(posedge clock) disable iff (reset) (state_q == StFall) |-> (hold_cnt == '0));

  assign level     = level_q;
  assign peak      = peak_q;
  assign clip      = clip_q;
  assign err_count = err_q;

endmodule

// File: doc/vu_level_ctrl.md
Name: vu_level_ctrl

Overview:
Sequences the displayed VU-meter level between the UART receive path and the VGA renderer. Accepts validated sample bytes from the UART strobe pair (load/error) and produces three registered outputs for the renderer: a bar level with instant attack and per-frame decay, a peak-hold marker, and a clip indicator. It sits between the UART/data latch stage and the vga module. It replaces direct display of the raw latched byte.

Parameters:
DECAY_STEP, 4, amount subtracted from level per frame_tick when no larger sample arrives
HOLD_FRAMES, 30, frame_ticks the peak marker is held before it falls
PEAK_STEP, 2, amount subtracted from peak per frame_tick while falling
CLIP_THRESHOLD, 8'd240, sample value at or above which clip is asserted
CLIP_FRAMES, 60, frame_ticks clip stays asserted after the last clipping sample

Ports:
clock  input  1  block clock; all inputs synchronous to it
reset  input  1  asynchronous, active-high reset
enable  input  1  when low, state freezes and strobes are ignored
data_in  input  8  received UART byte
load  input  1  one-cycle strobe, data_in valid
error  input  1  framing error for the byte strobed by load
frame_tick  input  1  one-cycle pulse per video frame, already synchronised to clock
level  output  8  bar height for renderer
peak  output  8  peak-hold marker position
clip  output  1  clip indicator
err_count  output  8  saturating count of rejected bytes

Behaviour:
- Reset (async, active-high): level=0, peak=0, clip=0, err_count=0, peak FSM=HOLD, hold_cnt=0, clip_cnt=0. Reset mid-operation clears everything immediately.
- enable=0: all registers hold; load and frame_tick are ignored (not queued).
- Sample acceptance: sample_ok = load & ~error. load & error -> err_count+1, saturating at 255; level, peak and clip unaffected.
- Level, one cycle latency, registered:
  - dec = (level > DECAY_STEP) ? level-DECAY_STEP : 0, computed only when frame_tick=1, otherwise dec=level.
  - level_next = sample_ok ? max(data_in, dec) : dec.
  - A sample and frame_tick in the same cycle: decay is applied first, then max with the sample.
- Peak FSM, states HOLD and FALL:
  - Any state, sample_ok & data_in >= peak -> peak=data_in, hold_cnt=0, state=HOLD. Equality restarts the hold.
  - HOLD: on each frame_tick hold_cnt+1. When hold_cnt reaches HOLD_FRAMES-1 on a frame_tick -> state=FALL. This gives exactly HOLD_FRAMES ticks of hold.
  - FALL: on each frame_tick, peak = saturating peak-PEAK_STEP. peak never drops below level: peak_next = max(peak_dec, level_next). When peak_next == level_next, the FSM stays in FALL and tracks level.
  - A sample that refreshes peak takes priority over a frame_tick in the same cycle.
- Clip:
  - sample_ok & data_in >= CLIP_THRESHOLD -> clip=1, clip_cnt=CLIP_FRAMES.
  - Otherwise, on each frame_tick with clip_cnt>0: clip_cnt-1. clip deasserts on the tick where clip_cnt goes 1->0.
  - A clipping sample coincident with a frame_tick reloads the counter; it does not decrement.
- Invariant: peak >= level on every cycle after reset.
- Counter widths are sized by $clog2 of their parameter+1. Parameters of 0 are illegal, and this is checked by elaboration assertion.

Decomposition:
- Package vu_pkg holds LEVEL_W=8, state enum {HOLD, FALL}, and the default constants above so that vga shares LEVEL_W.
- One natural sub-module: frame_down_counter, a loadable, frame_tick-decremented counter with a zero flag. It is instantiated twice, once for hold_cnt and once for clip_cnt.
- Saturating subtract/max stays inline.

Test Plan:
1. Reset. Then load data_in=100, error=0 -> next cycle level=100, peak=100, clip=0, err_count=0.
2. Level 100, no samples, 3 frame_ticks -> level 96, 92, 88. Peak stays 100 for 30 ticks, then falls by 2 per tick but never below level. Level decays to 0 after 25 ticks total and then stays at 0.
3. Same cycle: frame_tick plus load 90 with level=92 -> level=90 (max(88,90)). Load 80 instead -> level=88.
4. load with error=1, 300 times -> err_count saturates at 255. level, peak and clip stay unchanged.
5. Load 240 -> clip=1. 59 frame_ticks -> still 1. 60th tick -> 0. A load of 250 at tick 30 reloads the counter, and clip then lasts 60 more ticks.
6. enable=0 during frame_ticks and loads -> all outputs frozen. Assert reset while in FALL -> all outputs 0 asynchronously, before the next clock edge.
